// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host handshake and core control signals of the run sequencer
interface run_sequencer_if #(
  parameter int CW = 16
);
  logic start;
  logic core_done;
  logic core_rst;
  logic core_req;
  logic busy;
  logic done;
  logic timeout;
  logic [CW-1:0] cycle_cnt;
  modport master (
    input  start, core_done,
    output core_rst, core_req, busy, done, timeout, cycle_cnt
  );
  modport slave (
    output start, core_done,
    input  core_rst, core_req, busy, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: launches the core, times its run; watchdog enabled by RUN_SEQUENCER_TIMEOUT_EN
module run_sequencer #(
  parameter int CW = 16,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT_CYC = 4000
) (
  input logic clk,
  input logic reset,
  run_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RESET_CORE, REQ, RUN, DONE} state_t;
  state_t state, nxt;
  logic [3:0] hold;
  logic [CW-1:0] cnt, cnt_inc;
  logic to, wd_hit;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  assign wd_hit = cnt_inc == CW'(TIMEOUT_CYC);
`else
  assign wd_hit = 1'b0;
`endif
  // next state; start low aborts every active state, core_done only counts in RUN
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = bus.start ? RESET_CORE : IDLE;
      RESET_CORE: nxt = !bus.start ? IDLE : hold == 4'd0 ? REQ : RESET_CORE;
      REQ:        nxt = bus.start ? RUN : IDLE;
      RUN:        nxt = !bus.start ? IDLE : (bus.core_done || wd_hit) ? DONE : RUN;
      DONE:       nxt = bus.start ? DONE : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  // state register, reset-hold countdown, run counter and timeout flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      hold <= '0;
      cnt <= '0;
      to <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        hold <= 4'(RST_CYC - 1);
        cnt <= '0;
        to <= 1'b0;
      end
      if (state == RESET_CORE && hold != 4'd0) hold <= hold - 4'd1;
      if (state == RUN) begin
        cnt <= cnt_inc;
        to <= bus.start && !bus.core_done && wd_hit;
      end
    end
  assign bus.core_rst = state == IDLE || state == RESET_CORE;
  assign bus.core_req = state == REQ;
  assign bus.busy = state == RESET_CORE || state == REQ || state == RUN;
  assign bus.done = state == DONE;
  assign bus.timeout = to;
  assign bus.cycle_cnt = cnt;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer (watchdog cases need RUN_SEQUENCER_TIMEOUT_EN)
module tb_run_sequencer;
  localparam int RST_CYC = 2;
  typedef struct packed {
    logic d;
    logic t;
    logic [15:0] c;
  } exp_t;
  logic clk, reset;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t e;
  bit ok;
  run_sequencer_if #(.CW(16)) bus ();
  run_sequencer #(.CW(16), .RST_CYC(RST_CYC), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input int budget, output bit res);
    res = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done || !bus.busy) begin
        res = 1;
        break;
      end
      step();
    end
  endtask
  task automatic launch(input string tag);
    bus.start = 1;
    for (int i = 0; i < RST_CYC; i++) begin
      step();
      total++;
      if (bus.core_rst !== 1 || bus.core_req !== 0 || bus.busy !== 1 || bus.done !== 0 || bus.cycle_cnt !== 0) begin
        bad++;
        $display("FAIL %s rst_phase%0d: rst=%b req=%b busy=%b done=%b cnt=%0d want 1 0 1 0 0", tag, i, bus.core_rst, bus.core_req, bus.busy, bus.done, bus.cycle_cnt);
      end
    end
    step();
    total++;
    if (bus.core_rst !== 0 || bus.core_req !== 1 || bus.busy !== 1 || bus.done !== 0) begin
      bad++;
      $display("FAIL %s req_phase: rst=%b req=%b busy=%b done=%b want 0 1 1 0", tag, bus.core_rst, bus.core_req, bus.busy, bus.done);
    end
    step();
    total++;
    if (bus.core_rst !== 0 || bus.core_req !== 0 || bus.busy !== 1 || bus.done !== 0) begin
      bad++;
      $display("FAIL %s run1: rst=%b req=%b busy=%b done=%b want 0 0 1 0", tag, bus.core_rst, bus.core_req, bus.busy, bus.done);
    end
  endtask
  task automatic test_reset();
    reset = 0;
    bus.start = 0;
    bus.core_done = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.core_rst !== 1 || bus.core_req !== 0 || bus.busy !== 0 || bus.done !== 0 || bus.timeout !== 0 || bus.cycle_cnt !== 0) begin
      bad++;
      $display("FAIL reset: rst=%b req=%b busy=%b done=%b to=%b cnt=%0d want 1 0 0 0 0 0", bus.core_rst, bus.core_req, bus.busy, bus.done, bus.timeout, bus.cycle_cnt);
    end
    reset = 1;
    repeat (3) step();
  endtask
  task automatic test_normal();
    launch("normal");
    repeat (9) step();
    bus.core_done = 1;
    q.push_back('{1'b1, 1'b0, 16'd10});
    step();
    bus.core_done = 0;
    wait_done(5, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL normal_result: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    repeat (2) step();
    total++;
    if (bus.done !== 1 || bus.core_rst !== 0 || bus.cycle_cnt !== 16'd10) begin
      bad++;
      $display("FAIL normal_hold: done=%b rst=%b cnt=%0d want 1 0 10", bus.done, bus.core_rst, bus.cycle_cnt);
    end
    bus.start = 0;
    step();
    total++;
    if (bus.done !== 0 || bus.core_rst !== 1 || bus.busy !== 0) begin
      bad++;
      $display("FAIL normal_release: done=%b rst=%b busy=%b want 0 1 0", bus.done, bus.core_rst, bus.busy);
    end
  endtask
  task automatic test_stale();
    bus.core_done = 1;
    launch("stale");
    bus.core_done = 0;
    repeat (24) step();
    total++;
    if (bus.done !== 0 || bus.busy !== 1 || bus.cycle_cnt !== 16'd24) begin
      bad++;
      $display("FAIL stale_run25: done=%b busy=%b cnt=%0d want 0 1 24", bus.done, bus.busy, bus.cycle_cnt);
    end
    bus.core_done = 1;
    q.push_back('{1'b1, 1'b0, 16'd25});
    step();
    bus.core_done = 0;
    wait_done(5, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL stale_result: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    bus.start = 0;
    step();
  endtask
  task automatic test_abort();
    launch("abort");
    repeat (6) step();
    bus.start = 0;
    q.push_back('{1'b0, 1'b0, 16'd7});
    step();
    e = q.pop_front();
    total++;
    if (bus.busy !== 0 || bus.core_rst !== 1 || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL abort_result: busy=%b rst=%b done=%b to=%b cnt=%0d want 0 1 %b %b %0d", bus.busy, bus.core_rst, bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
  endtask
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  task automatic test_watchdog();
    launch("wd");
    q.push_back('{1'b1, 1'b1, 16'd50});
    wait_done(100, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL wd_expire: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    bus.start = 0;
    step();
    launch("wd_race");
    repeat (49) step();
    bus.core_done = 1;
    q.push_back('{1'b1, 1'b0, 16'd50});
    step();
    bus.core_done = 0;
    wait_done(5, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL wd_race: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    bus.start = 0;
    step();
  endtask
`endif
  task automatic test_async_reset();
    launch("async");
    repeat (3) step();
    #3 reset = 0;
    #1;
    total++;
    if (bus.core_rst !== 1 || bus.busy !== 0 || bus.cycle_cnt !== 0 || bus.core_req !== 0 || bus.done !== 0) begin
      bad++;
      $display("FAIL async_reset: rst=%b busy=%b cnt=%0d req=%b done=%b want 1 0 0 0 0", bus.core_rst, bus.busy, bus.cycle_cnt, bus.core_req, bus.done);
    end
    bus.start = 0;
    #2 reset = 1;
    repeat (2) step();
  endtask
  task automatic test_back_to_back();
    launch("b2b_first");
    repeat (3) step();
    bus.core_done = 1;
    q.push_back('{1'b1, 1'b0, 16'd4});
    step();
    bus.core_done = 0;
    wait_done(5, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL b2b_first: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    bus.start = 0;
    step();
    total++;
    if (bus.done !== 0 || bus.core_rst !== 1 || bus.cycle_cnt !== 16'd4) begin
      bad++;
      $display("FAIL b2b_idle: done=%b rst=%b cnt=%0d want 0 1 4", bus.done, bus.core_rst, bus.cycle_cnt);
    end
    launch("b2b_second");
    repeat (2) step();
    bus.core_done = 1;
    q.push_back('{1'b1, 1'b0, 16'd3});
    step();
    bus.core_done = 0;
    wait_done(5, ok);
    e = q.pop_front();
    total++;
    if (!ok || bus.done !== e.d || bus.timeout !== e.t || bus.cycle_cnt !== e.c) begin
      bad++;
      $display("FAIL b2b_second: done=%b to=%b cnt=%0d want %b %b %0d", bus.done, bus.timeout, bus.cycle_cnt, e.d, e.t, e.c);
    end
    bus.start = 0;
    step();
  endtask
  initial begin
    test_reset();
    test_normal();
    test_stale();
    test_abort();
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    test_watchdog();
`endif
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
